// File: rtl/huffman_stream_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : huffman_stream_scheduler
//  Purpose  : Merges the Y/Cb/Cr entropy-coder word streams into a single
//             variable-length code stream in JPEG MCU order (Y, Cb, Cr block
//             per MCU), with per-channel FIFOs and a ready/valid output.
//  Revision : 1.0  initial release
// ============================================================================
module huffman_stream_scheduler #(
    parameter int CODE_W     = 32,
    parameter int LEN_W      = 6,
    parameter int FIFO_DEPTH = 8,
    parameter int MCU_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic [2:0]            in_valid,
    output logic [2:0]            in_ready,
    input  logic [3*CODE_W-1:0]   in_code,
    input  logic [3*LEN_W-1:0]    in_len,
    input  logic [2:0]            in_eob,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CODE_W-1:0]     out_code,
    output logic [LEN_W-1:0]      out_len,
    output logic                  out_eob,
    output logic [1:0]            out_ch,
    output logic                  mcu_done,
    output logic [MCU_W-1:0]      mcu_count
);

    // One FIFO entry packs {eob, len, code}.
    localparam int ENT_W = CODE_W + LEN_W + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        SERVE_Y  = 2'd0,
        SERVE_CB = 2'd1,
        SERVE_CR = 2'd2
    } state_t;

    state_t cur_ch_q, cur_ch_d;

    logic [2:0]         fifo_empty;
    logic [2:0]         fifo_full;
    logic [2:0]         fifo_pop;
    logic [3*ENT_W-1:0] fifo_head;

    logic [ENT_W-1:0]   head_w;
    logic               head_empty_w;
    logic               load_w;
    logic               accept_w;

    logic               out_valid_q, out_valid_d;
    logic [CODE_W-1:0]  out_code_q,  out_code_d;
    logic [LEN_W-1:0]   out_len_q,   out_len_d;
    logic               out_eob_q,   out_eob_d;
    logic [1:0]         out_ch_q,    out_ch_d;
    logic               mcu_done_q,  mcu_done_d;
    logic [MCU_W-1:0]   mcu_count_q, mcu_count_d;

    // ------------------------------------------------------------------
    // Per-channel FIFOs. Ready comes from the registered count only, so a
    // pop from a full FIFO does not open the slot until the next cycle.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_fifo
            logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
            logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
            logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
            logic [CNT_W-1:0] cnt_q,    cnt_d;
            logic             wr_en;

            assign fifo_full[gi]  = (cnt_q == CNT_FULL);
            assign fifo_empty[gi] = (cnt_q == '0);
            assign wr_en          = in_valid[gi] && !fifo_full[gi] && !clear;
            assign fifo_head[gi*ENT_W +: ENT_W] = mem_q[rd_ptr_q];

            // Pointer and occupancy update; clear flushes the FIFO and drops any write.
            always_comb begin
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                cnt_d    = cnt_q;
                if (clear) begin
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    cnt_d    = '0;
                end else begin
                    if (wr_en) begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                    if (fifo_pop[gi]) begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                    case ({wr_en, fifo_pop[gi]})
                        2'b10:   cnt_d = cnt_q + 1'b1;
                        2'b01:   cnt_d = cnt_q - 1'b1;
                        default: cnt_d = cnt_q;
                    endcase
                end
            end

            // Pointer and occupancy registers.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    cnt_q    <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    cnt_q    <= cnt_d;
                end
            end

            // Storage array; contents are don't-care while the count says empty.
            always_ff @(posedge clk) begin
                if (wr_en) begin
                    mem_q[wr_ptr_q] <= {in_eob[gi],
                                        in_len[gi*LEN_W +: LEN_W],
                                        in_code[gi*CODE_W +: CODE_W]};
                end
            end
        end
    endgenerate

    assign in_ready = ~fifo_full;

    // Select the head entry of the FIFO currently being served.
    always_comb begin
        head_w       = fifo_head[0 +: ENT_W];
        head_empty_w = fifo_empty[0];
        case (cur_ch_q)
            SERVE_CB: begin
                head_w       = fifo_head[ENT_W +: ENT_W];
                head_empty_w = fifo_empty[1];
            end
            SERVE_CR: begin
                head_w       = fifo_head[2*ENT_W +: ENT_W];
                head_empty_w = fifo_empty[2];
            end
            default: begin
                head_w       = fifo_head[0 +: ENT_W];
                head_empty_w = fifo_empty[0];
            end
        endcase
    end

    assign accept_w = out_valid_q && out_ready;
    // Only the served channel may issue; other channels wait even if non-empty.
    assign load_w   = (!out_valid_q || out_ready) && !head_empty_w && !clear;

    // Scheduler next state, output-register load and MCU accounting.
    always_comb begin
        cur_ch_d    = cur_ch_q;
        out_valid_d = out_valid_q;
        out_code_d  = out_code_q;
        out_len_d   = out_len_q;
        out_eob_d   = out_eob_q;
        out_ch_d    = out_ch_q;
        mcu_done_d  = 1'b0;
        mcu_count_d = mcu_count_q;
        fifo_pop    = 3'b000;
        if (clear) begin
            cur_ch_d    = SERVE_Y;
            out_valid_d = 1'b0;
            out_code_d  = '0;
            out_len_d   = '0;
            out_eob_d   = 1'b0;
            out_ch_d    = 2'd0;
            mcu_count_d = '0;
        end else begin
            // The Cr end-of-block word leaving downstream closes one MCU.
            if (accept_w && (out_ch_q == 2'd2) && out_eob_q) begin
                mcu_done_d  = 1'b1;
                mcu_count_d = mcu_count_q + 1'b1;
            end
            if (load_w) begin
                fifo_pop    = 3'b001 << cur_ch_q;
                out_valid_d = 1'b1;
                out_code_d  = head_w[CODE_W-1:0];
                out_len_d   = head_w[CODE_W +: LEN_W];
                out_eob_d   = head_w[ENT_W-1];
                out_ch_d    = cur_ch_q;
                // Advance to the next component only when its block ends.
                if (head_w[ENT_W-1]) begin
                    case (cur_ch_q)
                        SERVE_Y:  cur_ch_d = SERVE_CB;
                        SERVE_CB: cur_ch_d = SERVE_CR;
                        default:  cur_ch_d = SERVE_Y;
                    endcase
                end
            end else if (accept_w) begin
                out_valid_d = 1'b0;
            end
        end
    end

    // Scheduler state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_ch_q <= SERVE_Y;
        end else begin
            cur_ch_q <= cur_ch_d;
        end
    end

    // Output register and MCU counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_code_q  <= '0;
            out_len_q   <= '0;
            out_eob_q   <= 1'b0;
            out_ch_q    <= 2'd0;
            mcu_done_q  <= 1'b0;
            mcu_count_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_code_q  <= out_code_d;
            out_len_q   <= out_len_d;
            out_eob_q   <= out_eob_d;
            out_ch_q    <= out_ch_d;
            mcu_done_q  <= mcu_done_d;
            mcu_count_q <= mcu_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_code  = out_code_q;
    assign out_len   = out_len_q;
    assign out_eob   = out_eob_q;
    assign out_ch    = out_ch_q;
    assign mcu_done  = mcu_done_q;
    assign mcu_count = mcu_count_q;

endmodule
`default_nettype wire

// File: tb/tb_huffman_stream_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_huffman_stream_scheduler
//  Purpose  : Self-checking bench for huffman_stream_scheduler. A queue-based
//             model keeps every accepted word per component and predicts the
//             merged stream as whole blocks in Y, Cb, Cr order.
//  Revision : 1.0  initial release
// ============================================================================
module tb_huffman_stream_scheduler;

    localparam int CW    = 32;
    localparam int LW    = 6;
    localparam int DEPTH = 8;
    // Narrow MCU counter so the wrap is reachable in a short run.
    localparam int MW    = 4;

    typedef struct packed {
        logic          eob;
        logic [LW-1:0] len;
        logic [CW-1:0] code;
    } word_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            clear = 1'b0;
    logic [2:0]      in_valid = 3'b000;
    logic [2:0]      in_ready;
    logic [3*CW-1:0] in_code;
    logic [3*LW-1:0] in_len;
    logic [2:0]      in_eob;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [CW-1:0]   out_code;
    logic [LW-1:0]   out_len;
    logic            out_eob;
    logic [1:0]      out_ch;
    logic            mcu_done;
    logic [MW-1:0]   mcu_count;

    word_t drv [3];

    assign in_code = {drv[2].code, drv[1].code, drv[0].code};
    assign in_len  = {drv[2].len,  drv[1].len,  drv[0].len};
    assign in_eob  = {drv[2].eob,  drv[1].eob,  drv[0].eob};

    huffman_stream_scheduler #(
        .CODE_W(CW), .LEN_W(LW), .FIFO_DEPTH(DEPTH), .MCU_W(MW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_code(in_code), .in_len(in_len), .in_eob(in_eob),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_code(out_code), .out_len(out_len), .out_eob(out_eob),
        .out_ch(out_ch), .mcu_done(mcu_done), .mcu_count(mcu_count)
    );

    always #5 clk = ~clk;

    // Reference model state
    word_t         q_y[$], q_cb[$], q_cr[$];
    int            model_ch;
    logic [MW-1:0] model_cnt;
    logic          exp_done;
    logic [2:0]    acc;
    int            obs_ch[$];
    logic          prev_stall;
    word_t         held;
    logic [1:0]    held_ch;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        q_y.delete(); q_cb.delete(); q_cr.delete();
        model_ch   = 0;
        model_cnt  = '0;
        exp_done   = 1'b0;
        prev_stall = 1'b0;
    endtask

    function automatic word_t mk(input logic [CW-1:0] c, input int l, input logic e);
        word_t w;
        w.code = c;
        w.len  = LW'(l);
        w.eob  = e;
        return w;
    endfunction

    // Observes one clock period at the falling edge: handshakes seen here
    // complete on the next rising edge.
    task automatic monitor();
        word_t w, e;
        int    qs;
        acc = 3'b000;
        if (!rst_n) begin
            model_reset();
            return;
        end
        check("mcu_done", mcu_done, exp_done);
        check("mcu_count", mcu_count, model_cnt);
        if (prev_stall) begin
            check("hold_valid", out_valid, 1);
            check("hold_word", {out_eob, out_len, out_code}, held);
            check("hold_ch", out_ch, held_ch);
        end
        exp_done = 1'b0;
        if (clear) begin
            model_reset();
            return;
        end
        for (int c = 0; c < 3; c++) begin
            if (in_valid[c] && in_ready[c]) begin
                acc[c] = 1'b1;
                case (c)
                    0:       q_y.push_back(drv[c]);
                    1:       q_cb.push_back(drv[c]);
                    default: q_cr.push_back(drv[c]);
                endcase
            end
        end
        if (out_valid && out_ready) begin
            w = {out_eob, out_len, out_code};
            obs_ch.push_back(int'(out_ch));
            check("out_ch", out_ch, model_ch);
            case (model_ch)
                0:       qs = q_y.size();
                1:       qs = q_cb.size();
                default: qs = q_cr.size();
            endcase
            if (qs == 0) begin
                check("spurious_out", out_valid, 0);
            end else begin
                case (model_ch)
                    0:       e = q_y.pop_front();
                    1:       e = q_cb.pop_front();
                    default: e = q_cr.pop_front();
                endcase
                check("out_word", w, e);
                if (e.eob) begin
                    if (model_ch == 2) begin
                        model_cnt = model_cnt + 1'b1;
                        exp_done  = 1'b1;
                    end
                    model_ch = (model_ch + 1) % 3;
                end
            end
        end
        prev_stall = out_valid && !out_ready;
        held       = {out_eob, out_len, out_code};
        held_ch    = out_ch;
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int ch, input word_t w);
        int guard;
        guard = 0;
        drv[ch] = w;
        in_valid[ch] = 1'b1;
        do begin
            cycle();
            guard++;
        end while (!acc[ch] && guard < 200);
        if (!acc[ch]) check("send_timeout", in_ready[ch], 1);
        in_valid[ch] = 1'b0;
    endtask

    task automatic drain(input int n);
        out_ready = 1'b1;
        repeat (n) cycle();
    endtask

    function automatic word_t rand_word();
        return mk($urandom, int'($urandom_range(0, 40)), ($urandom_range(0, 3) == 0));
    endfunction

    function automatic int cur_q_size();
        case (model_ch)
            0:       return q_y.size();
            1:       return q_cb.size();
            default: return q_cr.size();
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int    nacc, idx, guard;
        int    exp_order [9];
        word_t wa, wb, wc, wz;

        for (int c = 0; c < 3; c++) drv[c] = '0;
        acc = 3'b000;
        model_reset();
        exp_order = '{0, 0, 0, 0, 1, 1, 2, 2, 2};

        // ---------------- reset ----------------
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_in_ready", in_ready, 3'b111);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_code", out_code, 0);
        check("rst_out_len", out_len, 0);
        check("rst_out_eob", out_eob, 0);
        check("rst_out_ch", out_ch, 0);
        check("rst_mcu_done", mcu_done, 0);
        check("rst_mcu_count", mcu_count, 0);

        // ---------------- ordering: Cr, Cb, Y arrive in that order ----------------
        out_ready = 1'b1;
        obs_ch.delete();
        for (int k = 0; k < 3; k++) send(2, mk(32'hC200_0000 + k, 5 + k, k == 2));
        for (int k = 0; k < 2; k++) send(1, mk(32'hC100_0000 + k, 3, k == 1));
        for (int k = 0; k < 4; k++) send(0, mk(32'hC000_0000 + k, 7, k == 3));
        drain(12);
        check("order_count", obs_ch.size(), 9);
        for (int k = 0; k < 9 && k < obs_ch.size(); k++) check("order_ch", obs_ch[k], exp_order[k]);
        check("order_mcu", mcu_count, 1);

        // ---------------- latency and throughput ----------------
        wa = mk(32'hAAAA_0001, 10, 1'b0);
        wb = mk(32'hBBBB_0002, 11, 1'b0);
        wc = mk(32'hCCCC_0003, 0, 1'b0);
        drv[0] = wa; in_valid[0] = 1'b1;
        cycle();
        check("lat_not_yet", out_valid, 0);
        drv[0] = wb;
        cycle();
        check("lat_valid", out_valid, 1);
        check("lat_A", out_code, wa.code);
        drv[0] = wc;
        cycle();
        check("thr_B", out_code, wb.code);
        in_valid[0] = 1'b0;
        cycle();
        check("thr_C", out_code, wc.code);
        check("thr_C_valid", out_valid, 1);
        cycle();
        check("thr_idle", out_valid, 0);

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        nacc = 0;
        idx  = 0;
        drv[0] = mk(32'hB0B0_0000, 4, 1'b0);
        in_valid[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cycle();
            if (acc[0]) begin
                nacc++;
                idx++;
                drv[0] = mk(32'hB0B0_0000 + idx, 4, idx == 11);
            end
            check("bp_in_ready", in_ready[0], nacc < 9);
        end
        out_ready = 1'b1;
        guard = 0;
        while (idx < 12 && guard < 100) begin
            cycle();
            guard++;
            if (acc[0]) begin
                idx++;
                drv[0] = mk(32'hB0B0_0000 + idx, 4, idx == 11);
            end
        end
        in_valid[0] = 1'b0;
        drain(20);
        check("bp_sent", idx, 12);
        check("bp_all_out", q_y.size(), 0);

        // ---------------- starvation: Cb served, Cb empty ----------------
        for (int k = 0; k < 8; k++) begin
            drv[0] = mk(32'h5700_0000 + k, 9, k == 7);
            drv[2] = mk(32'h5720_0000 + k, 2, k == 7);
            in_valid[0] = 1'b1;
            in_valid[2] = 1'b1;
            cycle();
            check("starve_acc", acc, 3'b101);
            check("starve_idle", out_valid, 0);
        end
        in_valid = 3'b000;
        cycle();
        check("starve_ready", in_ready, 3'b010);
        check("starve_idle2", out_valid, 0);
        obs_ch.delete();
        send(1, mk(32'h5710_0000, 1, 1'b1));
        drain(30);
        check("starve_first", obs_ch.size() > 0 ? obs_ch[0] : 9, 1);
        check("starve_drained", q_y.size() + q_cr.size(), 0);

        // ---------------- clear mid-block ----------------
        out_ready = 1'b0;
        send(1, mk(32'hC1EA_0001, 6, 1'b0));
        send(1, mk(32'hC1EA_0002, 6, 1'b0));
        cycle();
        clear = 1'b1;
        drv[0] = mk(32'hDEAD_0000, 8, 1'b1);
        in_valid[0] = 1'b1;
        cycle();
        clear = 1'b0;
        in_valid[0] = 1'b0;
        check("clr_valid", out_valid, 0);
        check("clr_ready", in_ready, 3'b111);
        check("clr_mcu", mcu_count, 0);
        check("clr_done", mcu_done, 0);
        out_ready = 1'b1;
        obs_ch.delete();
        wz = mk(32'h2222_0001, 12, 1'b1);
        send(0, wz);
        drain(5);
        check("clr_next_ch", obs_ch.size() > 0 ? obs_ch[0] : 9, 0);
        check("clr_count", obs_ch.size(), 1);

        // ---------------- MCU counter wrap ----------------
        send(1, mk(32'h3000_0001, 0, 1'b1));
        send(2, mk(32'h3000_0002, 0, 1'b1));
        for (int m = 0; m < 16; m++) begin
            send(0, mk(32'h4000_0000 + m, 0, 1'b1));
            send(1, mk(32'h4100_0000 + m, 0, 1'b1));
            send(2, mk(32'h4200_0000 + m, 0, 1'b1));
        end
        drain(5);
        check("wrap_count", mcu_count, 1);
        check("wrap_ch", model_ch, 0);

        // ---------------- randomized traffic ----------------
        for (int c = 0; c < 3; c++) drv[c] = rand_word();
        for (int t = 0; t < 4000; t++) begin
            for (int c = 0; c < 3; c++) begin
                if (!in_valid[c] || acc[c]) begin
                    in_valid[c] = ($urandom_range(0, 2) != 0);
                    drv[c] = rand_word();
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            clear = ($urandom_range(0, 499) == 0);
            cycle();
        end
        clear = 1'b0;
        in_valid = 3'b000;
        drain(60);
        check("rand_drain", cur_q_size(), 0);

        // ---------------- asynchronous reset mid-block ----------------
        out_ready = 1'b0;
        send(0, mk(32'h7700_0001, 3, 1'b0));
        send(1, mk(32'h7700_0002, 3, 1'b0));
        send(2, mk(32'h7700_0003, 3, 1'b0));
        rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_ready", in_ready, 3'b111);
        check("arst_mcu", mcu_count, 0);
        cycle();
        cycle();
        rst_n = 1'b1;
        drain(6);
        check("arst_no_word", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/huffman_stream_scheduler.md
Name: huffman_stream_scheduler

Overview:
Merges the three per-component entropy-coder outputs (Y, Cb, Cr) into one variable-length code stream in JPEG MCU order. It buffers each channel in a small FIFO and serves one channel at a time: all of Y's block, then Cb's, then Cr's, then back to Y. It sits between the three EntropyCoder channels and the bit-packer/stream generator. The merged output carries a backpressure handshake.

Parameters:
CODE_W, 32, width of one Huffman code word (code + appended amplitude bits), right-aligned
LEN_W, 6, width of the code-length field; it must hold values 0..CODE_W
FIFO_DEPTH, 8, entries per channel FIFO; must be a power of 2 and at least 2
MCU_W, 16, width of the MCU counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous flush at frame start
in_valid  in  3  per-channel word valid; bit0 = Y, bit1 = Cb, bit2 = Cr
in_ready  out  3  per-channel accept; equals "FIFO not full"
in_code  in  3*CODE_W  per-channel code word; channel i occupies bits [i*CODE_W +: CODE_W]
in_len  in  3*LEN_W  per-channel valid bit count of the code word
in_eob  in  3  per-channel flag marking the last word of an 8x8 block
out_valid  out  1  merged word valid
out_ready  in  1  downstream accept
out_code  out  CODE_W  merged code word
out_len  out  LEN_W  merged length
out_eob  out  1  last word of the current block
out_ch  out  2  source channel of the word (0, 1 or 2)
mcu_done  out  1  one-cycle pulse when the Cr block's eob word is accepted downstream
mcu_count  out  MCU_W  number of completed MCUs

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: all FIFOs empty, in_ready = 3'b111, cur_ch = 0, out_valid = 0, out_code = 0, out_len = 0, out_eob = 0, out_ch = 0, mcu_done = 0, mcu_count = 0.
- Input handshake: channel i writes its FIFO on a rising edge where in_valid[i] && in_ready[i]. Each of the three channels is independent, and simultaneous writes on all three are allowed.
- FIFO full: in_ready[i] = 0; the producer holds its word.
- FIFO bypass: none. A word written in cycle N is at the FIFO head in cycle N+1.
- Scheduler state cur_ch ∈ {SERVE_Y = 0, SERVE_CB = 1, SERVE_CR = 2}.
- Output register: it loads the head of FIFO[cur_ch] when (!out_valid || out_ready) and FIFO[cur_ch] is non-empty. out_ch is loaded with cur_ch at the same time.
- Latency: with an idle path and the channel currently served, a word accepted at edge N gives out_valid = 1 after edge N+1, i.e. 2 cycles.
- Throughput: one word per cycle while out_ready = 1.
- No reorder: cur_ch advances only when a word with eob = 1 is popped from FIFO[cur_ch]. On that pop, cur_ch moves 0→1→2→0.
  - Words from other channels wait in their FIFOs meanwhile.
  - The word popped in the next cycle comes from the new cur_ch. No idle bubble is required when that FIFO is non-empty.
- Starvation: if FIFO[cur_ch] is empty, nothing is issued, even if the other FIFOs hold data. This is intentional, because MCU order is mandatory.
- Output hold: while out_valid && !out_ready, all out_* fields are held stable.
- mcu_done: asserted for 1 cycle on the edge where the out_ch = 2, out_eob = 1 word is accepted (out_valid && out_ready). mcu_count increments on the same edge and wraps modulo 2^MCU_W.
- Zero-length words: in_len = 0 is legal. The word is forwarded unchanged, which matters for eob-carrying placeholders.
- in_len > CODE_W is a producer error. It is passed through unchecked.
- clear behaviour: when clear = 1, on the next edge:
  - all FIFOs are emptied, cur_ch = 0, out_valid = 0, mcu_count = 0, mcu_done = 0;
  - input writes in that same cycle are discarded;
  - clear has priority over every other event.
- Reset mid-block: all state is dropped immediately (asynchronous). No partial word is emitted after reset.
- Simultaneous write and read on the same FIFO while full: the read frees the slot, but in_ready is still computed from the registered count. The write is therefore refused that cycle, so there is no combinational ready path.

Test Plan:
- Ordering: Cr delivers its block (3 words, eob on the last) first, then Cb (2 words), then Y (4 words). Required: output sequence out_ch = 0,0,0,0,1,1,2,2,2 with eob on output words 4, 6 and 9; mcu_done pulses once; mcu_count = 1.
- Latency and throughput: with cur_ch = 0 and out_ready = 1, send Y words A, B, C on consecutive cycles. Required: out_valid rises 2 cycles after A is accepted; A, B, C appear on 3 consecutive cycles.
- Backpressure: hold out_ready = 0 for 10 cycles while Y streams 12 words. Required:
  - out_* stays stable;
  - in_ready[0] drops after 9 words have been accepted (8 in the FIFO plus 1 in the output register);
  - after release, all 12 words emerge in order with none lost.
- Starvation: cur_ch = 1 and FIFO Cb is empty, while Y and Cr FIFOs are full. Required: out_valid = 0 until a Cb word arrives, and that Cb word is output first.
- Wrap: run 65537 MCUs with MCU_W = 16. Required: mcu_count ends at 1, and cur_ch = 0 after each Cr eob.
- clear mid-block: assert clear after 2 Cb words are buffered. Required: next cycle out_valid = 0, in_ready = 111, cur_ch = 0; the next output word is from Y.
